// File: rtl/alu_instr_decoder.sv
// RV32I ALU instruction decoder: splits an instruction word into ALU fields,
// classifies it as R-type / I-type / illegal and queues it in a 2-entry buffer.
module alu_instr_decoder #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           opcode,
    output logic [2:0]           Funct3,
    output logic [6:0]           Funct7,
    output logic [11:0]          Imm_reg,
    output logic [4:0]           Shamt,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [4:0]           rd_addr,
    output logic                 is_rtype,
    output logic                 is_itype,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_r;
        logic        is_i;
        logic        illegal;
    } entry_t;

    entry_t                 dec;
    entry_t                 mem_q [2];
    entry_t                 mem_d [2];
    entry_t                 head;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             occ_q, occ_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   push, pop;
    logic                   legal;
    logic [1:0]             wr_en;

    // Illegal entries keep the raw extracted fields and carry a zero immediate.
    always_comb begin
        dec         = '0;
        dec.opcode  = instr[6:0];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct7  = instr[31:25];
        dec.shamt   = instr[24:20];
        legal       = 1'b0;
        if (instr[6:0] == OP_RTYPE) begin
            legal = (instr[31:25] == 7'b0000000) ||
                    (instr[31:25] == 7'b0100000 &&
                     (instr[14:12] == 3'b000 || instr[14:12] == 3'b101));
            dec.is_r = legal;
        end else if (instr[6:0] == OP_ITYPE) begin
            case (instr[14:12])
                3'b001:  legal = (instr[31:25] == 7'b0000000);
                3'b101:  legal = (instr[31:25] == 7'b0000000) ||
                                 (instr[31:25] == 7'b0100000);
                default: legal = 1'b1;
            endcase
            if (legal) begin
                dec.is_i = 1'b1;
                dec.imm  = instr[31:20];
                dec.rs2  = 5'd0;
                if (instr[14:12] != 3'b001 && instr[14:12] != 3'b101) begin
                    dec.funct7 = 7'd0;
                    dec.shamt  = 5'd0;
                end
            end
        end
        dec.illegal = !legal;
    end

    assign in_ready  = rst && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_d[i] = wr_en[i] ? dec : mem_q[i];
        end
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        occ_d    = occ_q + 2'(push) - 2'(pop);
        cnt_d    = cnt_q;
        if (pop && !head.illegal && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Fields read as zero whenever the buffer is empty.
    assign opcode      = out_valid ? head.opcode  : '0;
    assign Funct3      = out_valid ? head.funct3  : '0;
    assign Funct7      = out_valid ? head.funct7  : '0;
    assign Imm_reg     = out_valid ? head.imm     : '0;
    assign Shamt       = out_valid ? head.shamt   : '0;
    assign rs1_addr    = out_valid ? head.rs1     : '0;
    assign rs2_addr    = out_valid ? head.rs2     : '0;
    assign rd_addr     = out_valid ? head.rd      : '0;
    assign is_rtype    = out_valid && head.is_r;
    assign is_itype    = out_valid && head.is_i;
    assign illegal     = out_valid && head.illegal;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Bench for alu_instr_decoder: directed cases plus random traffic checked against
// a queue-based reference model that decodes words straight from the RV32I rules.
module tb_alu_instr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [11:0] Imm_reg;
    logic [4:0]  Shamt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        is_rtype;
    logic        is_itype;
    logic        illegal;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI  = 32'hFFF30293;
    localparam logic [31:0] I_SRAI  = 32'h40715093;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BADR  = 32'h402090B3;

    typedef struct {
        int opcode, f3, f7, imm, shamt, rs1, rs2, rd, is_r, is_i, ill;
    } ref_t;

    logic [31:0] model_q[$];
    int          model_cnt = 0;

    always #5 clk = ~clk;

    alu_instr_decoder #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7), .Imm_reg(Imm_reg),
        .Shamt(Shamt), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .is_rtype(is_rtype), .is_itype(is_itype), .illegal(illegal),
        .instr_count(instr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decoded view of a word, derived from the ISA field layout by shifting and masking.
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        r.opcode = int'(w & 32'h7f);
        r.rd     = int'((w >> 7) & 32'h1f);
        r.f3     = int'((w >> 12) & 32'h7);
        r.rs1    = int'((w >> 15) & 32'h1f);
        r.rs2    = int'((w >> 20) & 32'h1f);
        r.f7     = int'((w >> 25) & 32'h7f);
        r.shamt  = r.rs2;
        r.imm    = 0;
        r.is_r   = 0;
        r.is_i   = 0;
        r.ill    = 0;
        if (r.opcode == 51 && (r.f7 == 0 || (r.f7 == 32 && (r.f3 == 0 || r.f3 == 5)))) begin
            r.is_r = 1;
        end else if (r.opcode == 19 && !(r.f3 == 1 && r.f7 != 0) &&
                     !(r.f3 == 5 && r.f7 != 0 && r.f7 != 32)) begin
            r.is_i = 1;
            r.imm  = int'(w >> 20);
            r.rs2  = 0;
            if (r.f3 != 1 && r.f3 != 5) begin
                r.f7    = 0;
                r.shamt = 0;
            end
        end else begin
            r.ill = 1;
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic iv, input logic [31:0] w, input logic ordy);
        ref_t e;
        logic exp_rdy;
        @(negedge clk);
        rst = r; in_valid = iv; instr = w; out_ready = ordy;
        #1;
        exp_rdy = r && (model_q.size() < 2);
        e = '{default: 0};
        if (model_q.size() > 0) e = ref_decode(model_q[0]);
        check_eq("in_ready",    32'(in_ready),    32'(exp_rdy));
        check_eq("out_valid",   32'(out_valid),   32'(model_q.size() > 0));
        check_eq("instr_count", 32'(instr_count), model_cnt);
        check_eq("opcode",      32'(opcode),      e.opcode);
        check_eq("Funct3",      32'(Funct3),      e.f3);
        check_eq("Funct7",      32'(Funct7),      e.f7);
        check_eq("Imm_reg",     32'(Imm_reg),     e.imm);
        check_eq("Shamt",       32'(Shamt),       e.shamt);
        check_eq("rs1_addr",    32'(rs1_addr),    e.rs1);
        check_eq("rs2_addr",    32'(rs2_addr),    e.rs2);
        check_eq("rd_addr",     32'(rd_addr),     e.rd);
        check_eq("is_rtype",    32'(is_rtype),    e.is_r);
        check_eq("is_itype",    32'(is_itype),    e.is_i);
        check_eq("illegal",     32'(illegal),     e.ill);
        @(posedge clk);
        if (!r) begin
            model_q.delete();
            model_cnt = 0;
        end else begin
            if (model_q.size() > 0 && ordy) begin
                $display("[TB] pop instr=0x%08h r=%0d i=%0d ill=%0d", model_q[0], e.is_r, e.is_i, e.ill);
                if (e.ill == 0 && model_cnt < 65535) model_cnt++;
                void'(model_q.pop_front());
            end
            if (iv && exp_rdy) model_q.push_back(w);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int sel;
        w   = $urandom;
        sel = int'($urandom_range(0, 9));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (sel < 4)      w = {f7, w[24:7], 7'b0110011};
        else if (sel < 8) w = {f7, w[24:7], 7'b0010011};
        return w;
    endfunction

    initial begin
        rst = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, '0, 1'b1);

        // Single-instruction decodes
        step(1'b1, 1'b1, I_ADD, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, I_ADDI, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, I_SRAI, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);

        // Backpressure: third word held until a slot frees
        step(1'b1, 1'b1, I_ADD,  1'b0);
        step(1'b1, 1'b1, I_ADDI, 1'b0);
        step(1'b1, 1'b1, I_SRAI, 1'b0);
        step(1'b1, 1'b1, I_SRAI, 1'b1);
        step(1'b1, 1'b1, I_SRAI, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        check_eq("count_after_bp", 32'(instr_count), 32'd6);

        // Illegal encodings
        step(1'b1, 1'b1, I_ECALL, 1'b1);
        step(1'b1, 1'b1, I_BADR,  1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        check_eq("count_after_illegal", 32'(instr_count), 32'd6);

        // Reset with a full buffer
        step(1'b1, 1'b1, I_ADD,  1'b0);
        step(1'b1, 1'b1, I_SRAI, 1'b0);
        step(1'b0, 1'b1, I_ADDI, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 rand_instr(), ($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
